grf_write_arbiter: RTL and testbench

Shares the single GRF write port (A3/WD/En) between the pipeline W-stage writeback and an auxiliary multicycle-unit result port, and runs a post-reset zeroing sweep of registers 1..31. It sits between the W stage and the GRF instance, owns the GRF write-port inputs outright, and raises a stall request to the hazard unit when an auxiliary result has waited too long.

---
 rtl/grf_write_arbiter_pkg.sv | 17 +
 rtl/grf_write_arbiter_pending.sv | 64 ++++++
 rtl/grf_write_arbiter.sv | 105 ++++++++++
 tb/tb_grf_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_write_arbiter_pkg.sv
// grf_write_arbiter_pkg
//   Shared widths and FSM encoding for the GRF write-port arbiter and its
//   pending-entry buffer.
package grf_write_arbiter_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int AGE_W  = 4;

  // FSM encoding
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

endpackage

// File: rtl/grf_write_arbiter_pending.sv
// grf_wr_pending
//   One-entry holding buffer for an accepted aux result, with a saturating
//   age counter that drives the stall request.
// Ports:
//   clk, reset             clock, async active-low reset
//   capture                aux handshake this cycle
//   cap_addr, cap_data     aux destination / data to capture
//   drain                  GRF write slot used by this entry this cycle
//   wb_hit                 a real (non-r0) wb write happens this cycle
//   wb_addr                wb destination, for the drop-on-match check
//   pend_valid/addr/data   buffered entry
//   stall_req              entry has waited STARVE_LIMIT cycles or more
module grf_wr_pending
  import grf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [REG_W-1:0]  cap_data,
  input  logic              drain,
  input  logic              wb_hit,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [REG_W-1:0]  pend_data,
  output logic              stall_req
);

  localparam logic [AGE_W-1:0] LIMIT   = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [AGE_W-1:0] age;
  logic             drop;

  // A younger wb write to the same register makes the buffered data stale.
  assign drop = pend_valid & wb_hit & (wb_addr == pend_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      age        <= '0;
    end else if (capture) begin
      // r0 results are accepted but thrown away
      if (cap_addr != '0) begin
        pend_valid <= 1'b1;
        pend_addr  <= cap_addr;
        pend_data  <= cap_data;
      end
      age <= '0;
    end else if (drain | drop) begin
      pend_valid <= 1'b0;
    end else if (pend_valid && (age != AGE_MAX)) begin
      age <= age + AGE_W'(1);
    end
  end

  assign stall_req = pend_valid & (age >= LIMIT);

endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
//   Owns the single GRF write port. After reset it zeroes r1..r31 (unless
//   INIT_ENABLE = 0), then shares the port between W-stage writeback (always
//   first) and a one-entry buffer of auxiliary unit results.
// Ports:
//   clk, reset                      clock, async active-low reset
//   wb_en, wb_addr, wb_data         W-stage writeback
//   aux_valid, aux_ready,
//   aux_addr, aux_data              aux result handshake
//   grf_en, grf_a3, grf_wd          GRF write port
//   init_busy                       zeroing sweep in progress
//   stall_req                       freeze pipeline so pending entry drains
//   pend_valid, pend_addr, pend_data  pending entry, for forwarding
//
// state | meaning
// INIT  | zeroing sweep r1..r31; wb writes take priority and pause the sweep
// RUN   | wb writeback first, then pending aux drain
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int INIT_ENABLE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [REG_W-1:0]  wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [REG_W-1:0]  aux_data,
  output logic              grf_en,
  output logic [ADDR_W-1:0] grf_a3,
  output logic [REG_W-1:0]  grf_wd,
  output logic              init_busy,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [REG_W-1:0]  pend_data
);

  localparam logic RST_STATE = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;

  logic              state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              wb_hit;
  logic              drain;

  // r0 writes are not writes at all
  assign wb_hit = wb_en & (wb_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_STATE;
      sweep_cnt <= ADDR_W'(1);
    end else if ((state == ST_INIT) && !wb_hit) begin
      sweep_cnt <= sweep_cnt + ADDR_W'(1);
      if (sweep_cnt == LAST_REG) state <= ST_RUN;
    end
  end

  assign init_busy = (state == ST_INIT);
  // Gated by reset so the port is quiet while reset is held, even in RUN.
  assign aux_ready = reset & (state == ST_RUN) & ~pend_valid;
  assign drain     = (state == ST_RUN) & pend_valid & ~wb_hit;

  always_comb begin
    grf_en = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    if (reset) begin
      if (wb_hit) begin
        grf_en = 1'b1;
        grf_a3 = wb_addr;
        grf_wd = wb_data;
      end else if (state == ST_INIT) begin
        grf_en = 1'b1;
        grf_a3 = sweep_cnt;
      end else if (pend_valid) begin
        grf_en = 1'b1;
        grf_a3 = pend_addr;
        grf_wd = pend_data;
      end
    end
  end

  grf_wr_pending #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pending (
    .clk       (clk),
    .reset     (reset),
    .capture   (aux_valid & aux_ready),
    .cap_addr  (aux_addr),
    .cap_data  (aux_data),
    .drain     (drain),
    .wb_hit    (wb_hit),
    .wb_addr   (wb_addr),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .stall_req (stall_req)
  );

endmodule

// File: tb/tb_grf_write_arbiter.sv
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        grf_en;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic        init_busy;
  logic        stall_req;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;

  grf_write_arbiter #(.STARVE_LIMIT(4), .INIT_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_addr(aux_addr), .aux_data(aux_data),
    .grf_en(grf_en), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .init_busy(init_busy), .stall_req(stall_req),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // reference model: sweep position, pending entry, its waiting time
  bit          m_init;
  int          m_sweep;
  bit          m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;
  int          m_age;
  bit          m_ready;
  bit          stale_written;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_init  = 1'b1;
    m_sweep = 1;
    m_pv    = 1'b0;
    m_pa    = '0;
    m_pd    = '0;
    m_age   = 0;
  endtask

  task automatic check_reset();
    chk("rst_grf_en", 32'(grf_en), 0);
    chk("rst_grf_a3", 32'(grf_a3), 0);
    chk("rst_grf_wd", grf_wd, 0);
    chk("rst_aux_ready", 32'(aux_ready), 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_pend_valid", 32'(pend_valid), 0);
    chk("rst_pend_addr", 32'(pend_addr), 0);
    chk("rst_pend_data", pend_data, 0);
    chk("rst_init_busy", 32'(init_busy), 1);
  endtask

  // Compare all outputs with the model at the falling edge.
  task automatic settle();
    logic        e_en;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    bit          wb_real;
    @(negedge clk);
    wb_real = wb_en && (wb_addr != 0);
    e_en = 1'b0; e_a3 = '0; e_wd = '0;
    if (wb_real) begin
      e_en = 1'b1; e_a3 = wb_addr; e_wd = wb_data;
    end else if (m_init) begin
      e_en = 1'b1; e_a3 = 5'(m_sweep); e_wd = '0;
    end else if (m_pv) begin
      e_en = 1'b1; e_a3 = m_pa; e_wd = m_pd;
    end
    m_ready = !m_init && !m_pv;
    chk("grf_en", 32'(grf_en), 32'(e_en));
    chk("grf_a3", 32'(grf_a3), 32'(e_a3));
    chk("grf_wd", grf_wd, e_wd);
    chk("aux_ready", 32'(aux_ready), 32'(m_ready));
    chk("init_busy", 32'(init_busy), 32'(m_init));
    chk("stall_req", 32'(stall_req), 32'(m_pv && (m_age >= 4)));
    chk("pend_valid", 32'(pend_valid), 32'(m_pv));
    if (m_pv) begin
      chk("pend_addr", 32'(pend_addr), 32'(m_pa));
      chk("pend_data", pend_data, m_pd);
    end
    if (grf_en && grf_a3 == 5'd9 && grf_wd == 32'h0000AAAA) stale_written = 1'b1;
  endtask

  // Step the model across the rising edge.
  task automatic advance();
    bit wb_real;
    bit hs;
    @(posedge clk);
    wb_real = wb_en && (wb_addr != 0);
    hs = aux_valid && m_ready;
    if (m_init) begin
      if (!wb_real) begin
        if (m_sweep == 31) m_init = 1'b0;
        m_sweep++;
      end
    end else if (hs) begin
      if (aux_addr != 0) begin
        m_pv = 1'b1; m_pa = aux_addr; m_pd = aux_data;
      end
      m_age = 0;
    end else if (m_pv && (!wb_real || wb_addr == m_pa)) begin
      m_pv = 1'b0;
    end else if (m_pv && m_age < 15) begin
      m_age++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    aux_valid = 0; aux_addr = 0; aux_data = 0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 31; i++) begin
      settle();
      chk({tag, "_en"}, 32'(grf_en), 1);
      chk({tag, "_a3"}, 32'(grf_a3), i);
      chk({tag, "_wd"}, grf_wd, 0);
      advance();
    end
    settle();
    chk({tag, "_busy_done"}, 32'(init_busy), 0);
    advance();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(posedge clk);
    #1;
    check_reset();
    reset = 1'b1;
  endtask

  initial begin
    stale_written = 1'b0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #3;
    check_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // full sweep, no traffic
    sweep_check("sweep");

    // aux addr 5 single handshake and drain
    aux_valid = 1; aux_addr = 5'd5; aux_data = 32'h00001234;
    settle();
    chk("aux5_ready", 32'(aux_ready), 1);
    advance();
    idle_inputs();
    settle();
    chk("aux5_en", 32'(grf_en), 1);
    chk("aux5_a3", 32'(grf_a3), 5);
    chk("aux5_wd", grf_wd, 32'h00001234);
    advance();
    settle();
    chk("aux5_cleared", 32'(pend_valid), 0);
    chk("aux5_ready_again", 32'(aux_ready), 1);
    advance();

    // starvation: wb busy to r8 holds off the drain of r3
    wb_en = 1; wb_addr = 5'd8; wb_data = 32'h88;
    aux_valid = 1; aux_addr = 5'd3; aux_data = 32'h33;
    settle(); advance();
    aux_valid = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("starve_wait", 32'(stall_req), 0);
      advance();
    end
    settle();
    chk("starve_stall", 32'(stall_req), 1);
    advance();
    wb_en = 0;
    settle();
    chk("starve_drain_a3", 32'(grf_a3), 3);
    advance();
    settle();
    chk("starve_stall_low", 32'(stall_req), 0);
    advance();

    // stale aux data dropped by a younger wb write
    wb_en = 1; wb_addr = 5'd8; wb_data = 32'h1;
    aux_valid = 1; aux_addr = 5'd9; aux_data = 32'h0000AAAA;
    settle(); advance();
    aux_valid = 0;
    wb_addr = 5'd9; wb_data = 32'h00005555;
    settle();
    chk("drop_wd", grf_wd, 32'h00005555);
    advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    chk("drop_no_stale", 32'(stale_written), 0);
    chk("drop_pend_clear", 32'(pend_valid), 0);

    // wb to r0 leaves the slot to the pending entry
    wb_en = 1; wb_addr = 5'd8; wb_data = 32'h2;
    aux_valid = 1; aux_addr = 5'd12; aux_data = 32'h0000BEEF;
    settle(); advance();
    aux_valid = 0;
    wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    settle();
    chk("r0_en", 32'(grf_en), 1);
    chk("r0_a3", 32'(grf_a3), 12);
    chk("r0_wd", grf_wd, 32'h0000BEEF);
    advance();
    idle_inputs();

    // reset mid-sweep at register 10
    do_reset();
    while (m_sweep != 10) begin settle(); advance(); end
    do_reset();
    sweep_check("resweep");

    // randomized traffic from reset, including wb writes during the sweep
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 15));
      wb_data   = $urandom;
      aux_valid = ($urandom_range(0, 1) == 1);
      aux_addr  = 5'($urandom_range(0, 15));
      aux_data  = $urandom;
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
